td4_reg_stage: RTL and testbench

- Architectural register stage of the TD4 4-bit CPU: registers A, B, OUT, program counter PC, carry flag C, plus a registered input port.
- Sits directly upstream of the four bit-slice 4:1 multiplexers that select the ALU source operand.
  - Bit i of reg_a, reg_b, in_q and constant 0 forms mux bit-slice i's c[3:0] = {0, in_q[i], reg_b[i], reg_a[i]}.
- Also sits downstream of the ALU: ALU result writes back here under one-hot load enables from the decoder.

---
 rtl/td4_reg_stage.sv | 90 +++++++++
 tb/tb_td4_reg_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/td4_reg_stage.sv
// TD4 architectural register stage: A, B, OUT, PC, carry flag and the registered input port.
// Optional TD4_IN_SYNC_EN puts a two-flop synchroniser on in_port instead of a single register.
module td4_reg_stage #(
    parameter int WIDTH    = 4,
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          ld,
    input  logic [WIDTH-1:0]    alu_y,
    input  logic                alu_carry,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    reg_a,
    output logic [WIDTH-1:0]    reg_b,
    output logic [WIDTH-1:0]    in_q,
    output logic [WIDTH-1:0]    out_port,
    output logic [PC_WIDTH-1:0] pc,
    output logic                cflag,
    output logic                ld_err
);

    logic [PC_WIDTH-1:0] jump_target;
    logic                multi_hot;
    logic                ld_a;
    logic                ld_b;
    logic                ld_out;
    logic                ld_pc;

    generate
        if (PC_WIDTH > WIDTH) begin : g_jump_zext
            assign jump_target = {{(PC_WIDTH-WIDTH){1'b0}}, alu_y};
        end else begin : g_jump_trunc
            assign jump_target = alu_y[PC_WIDTH-1:0];
        end
    endgenerate

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi_hot = (ld & (ld - 4'd1)) != 4'd0;
    assign ld_a      = (ld == 4'b0001);
    assign ld_b      = (ld == 4'b0010);
    assign ld_out    = (ld == 4'b0100);
    assign ld_pc     = (ld == 4'b1000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            pc       <= '0;
            cflag    <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            cflag <= alu_carry;
            if (ld_a)
                reg_a <= alu_y;
            if (ld_b)
                reg_b <= alu_y;
            if (ld_out)
                out_port <= alu_y;
            if (ld_pc)
                pc <= jump_target;
            else
                pc <= pc + 1'b1;
            if (multi_hot)
                ld_err <= 1'b1;
        end
    end

`ifdef TD4_IN_SYNC_EN
    logic [WIDTH-1:0] in_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_meta <= '0;
            in_q    <= '0;
        end else begin
            in_meta <= in_port;
            in_q    <= in_meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            in_q <= '0;
        else
            in_q <= in_port;
    end
`endif

endmodule

// File: tb/tb_td4_reg_stage.sv
// Bench for td4_reg_stage: vector table plus hand sequences, checked through an expectation queue,
// followed by a randomised run against a small reference model.
module tb_td4_reg_stage;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] o;
        logic [3:0] pc;
        logic       c;
        logic       err;
        logic [3:0] inq;
    } exp_t;

    typedef struct {
        logic [3:0] ld;
        logic [3:0] y;
        logic       carry;
        exp_t       e;
    } vec_t;

`ifdef TD4_IN_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ld;
    logic [3:0] alu_y;
    logic       alu_carry;
    logic [3:0] in_port;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] in_q;
    logic [3:0] out_port;
    logic [3:0] pc;
    logic       cflag;
    logic       ld_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vt[$];

    td4_reg_stage #(.WIDTH(4), .PC_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .alu_y     (alu_y),
        .alu_carry (alu_carry),
        .in_port   (in_port),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .in_q      (in_q),
        .out_port  (out_port),
        .pc        (pc),
        .cflag     (cflag),
        .ld_err    (ld_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o,
                                input logic [3:0] p, input logic c, input logic err,
                                input logic [3:0] inq);
        exp_t e;
        e.a = a; e.b = b; e.o = o; e.pc = p; e.c = c; e.err = err; e.inq = inq;
        return e;
    endfunction

    function automatic vec_t mv(input logic [3:0] l, input logic [3:0] y, input logic c, input exp_t e);
        vec_t v;
        v.ld = l; v.y = y; v.carry = c; v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".reg_a"},    {4'h0, reg_a},    {4'h0, e.a});
        chk({tag, ".reg_b"},    {4'h0, reg_b},    {4'h0, e.b});
        chk({tag, ".out_port"}, {4'h0, out_port}, {4'h0, e.o});
        chk({tag, ".pc"},       {4'h0, pc},       {4'h0, e.pc});
        chk({tag, ".cflag"},    {7'h0, cflag},    {7'h0, e.c});
        chk({tag, ".ld_err"},   {7'h0, ld_err},   {7'h0, e.err});
        chk({tag, ".in_q"},     {4'h0, in_q},     {4'h0, e.inq});
    endtask

    // Drive one instruction, queue its expected result, clock it and compare one step after the edge.
    task automatic apply(input string tag, input logic [3:0] l, input logic [3:0] y, input logic c,
                         input exp_t e);
        exp_t got;
        ld        = l;
        alu_y     = y;
        alu_carry = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".queue_empty"}, 8'h1, 8'h0);
        end else begin
            got = sb.pop_front();
            check_all(tag, got);
        end
    endtask

    initial begin
        logic [3:0] m_a, m_b, m_o, m_pc, m_s1, nld, ny, nin;
        logic       m_c, m_err, nc;
        exp_t       e;

        rst = 1'b1; ld = 4'h0; alu_y = 4'h0; alu_carry = 1'b0; in_port = 4'h0;

        // Reset state, before and after an edge under reset.
        #3;
        check_all("reset_async", mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0));
        @(posedge clk); #1;
        check_all("reset_held", mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++)
            vt.push_back(mv(4'h0, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h0, 4'((i + 1) % 16), 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h1, 4'hA, 1'b0, mk(4'hA, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h2, 4'h5, 1'b0, mk(4'hA, 4'h5, 4'h0, 4'h6, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h4, 4'h3, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'h7, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h8, 4'h6, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'h6, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h8, 4'hC, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'hC, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'hD, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h0, 4'h0, 1'b1, mk(4'hA, 4'h5, 4'h3, 4'hE, 1'b1, 1'b0, 4'h0)));
        vt.push_back(mv(4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'hF, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h8, 4'h2, 1'b1, mk(4'hA, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0, 4'h0)));
        vt.push_back(mv(4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'h3, 1'b0, 1'b0, 4'h0)));
        vt.push_back(mv(4'h3, 4'h7, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'h4, 1'b0, 1'b1, 4'h0)));
        for (int i = 0; i < 5; i++)
            vt.push_back(mv(4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'(5 + i), 1'b0, 1'b1, 4'h0)));
        vt.push_back(mv(4'hC, 4'h1, 1'b1, mk(4'hA, 4'h5, 4'h3, 4'hA, 1'b1, 1'b1, 4'h0)));
        vt.push_back(mv(4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'hB, 1'b0, 1'b1, 4'h0)));

        foreach (vt[i])
            apply($sformatf("vec%0d", i), vt[i].ld, vt[i].y, vt[i].carry, vt[i].e);

        // Input port latency: 0 -> 9.
        in_port = 4'h9;
        apply("in_edge1", 4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'hC, 1'b0, 1'b1, SYNC ? 4'h0 : 4'h9));
        apply("in_edge2", 4'h0, 4'h0, 1'b0, mk(4'hA, 4'h5, 4'h3, 4'hD, 1'b0, 1'b1, 4'h9));

        // Reset between edges with A = F, PC = 9 and a load pending.
        apply("pre_rst_a", 4'h1, 4'hF, 1'b0, mk(4'hF, 4'h5, 4'h3, 4'hE, 1'b0, 1'b1, 4'h9));
        apply("pre_rst_pc", 4'h8, 4'h9, 1'b1, mk(4'hF, 4'h5, 4'h3, 4'h9, 1'b1, 1'b1, 4'h9));
        ld = 4'h1; alu_y = 4'h5;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("rst_mid", mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0));
        #1;
        rst = 1'b0;
        apply("post_rst", 4'h0, 4'h0, 1'b0, mk(4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, SYNC ? 4'h0 : 4'h9));

        // Randomised run against a reference model.
        m_a = 4'h0; m_b = 4'h0; m_o = 4'h0; m_pc = 4'h1; m_c = 1'b0; m_err = 1'b0; m_s1 = 4'h9;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: nld = 4'h0;
                1: nld = 4'h1;
                2: nld = 4'h2;
                3: nld = 4'h4;
                4: nld = 4'h8;
                default: nld = 4'($urandom_range(0, 15));
            endcase
            ny  = 4'($urandom_range(0, 15));
            nc  = 1'($urandom_range(0, 1));
            nin = 4'($urandom_range(0, 15));
            in_port = nin;
            case (nld)
                4'h0: m_pc = m_pc + 4'h1;
                4'h1: begin m_a = ny; m_pc = m_pc + 4'h1; end
                4'h2: begin m_b = ny; m_pc = m_pc + 4'h1; end
                4'h4: begin m_o = ny; m_pc = m_pc + 4'h1; end
                4'h8: m_pc = ny;
                default: begin m_err = 1'b1; m_pc = m_pc + 4'h1; end
            endcase
            m_c = nc;
            e = mk(m_a, m_b, m_o, m_pc, m_c, m_err, SYNC ? m_s1 : nin);
            m_s1 = nin;
            apply($sformatf("rnd%0d", i), nld, ny, nc, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
